// File: rtl/comp_page_scheduler_pkg.sv
// Shared constants and types for the compression page scheduler.
package comp_page_scheduler_pkg;

    localparam int unsigned COMP_CORES = 4;
    localparam int unsigned PAGE_SIZE  = 4096;
    localparam int unsigned VADDR_BITS = 48;

    typedef logic [VADDR_BITS-1:0]         vaddr_t;
    typedef logic [$clog2(COMP_CORES)-1:0] core_id_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } sched_state_t;

endpackage

// File: rtl/comp_page_scheduler_arbiter.sv
// Round-robin pick of the first eligible core at or after the pointer.
module rr_credit_arbiter #(
    parameter  int unsigned N_CORES = 4,
    localparam int unsigned ID_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic [N_CORES-1:0] eligible,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant,
    output logic               any_grant
);

    // Scan cores starting at ptr, wrapping modulo N_CORES.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        any_grant = 1'b0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            idx = (32'(ptr) + i) % N_CORES;
            if (!any_grant && eligible[ID_W'(idx)]) begin
                any_grant = 1'b1;
                grant     = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/comp_page_scheduler.sv
// Splits a buffer into page requests, dispatches them round-robin under
// per-core credits, tracks completions and reports job runtime.
module comp_page_scheduler
    import comp_page_scheduler_pkg::*;
#(
    parameter  int unsigned N_CORES    = COMP_CORES,
    parameter  int unsigned PAGE_SIZE  = comp_page_scheduler_pkg::PAGE_SIZE,
    parameter  int unsigned CREDITS    = 2,
    parameter  int unsigned NPAGE_BITS = 16,
    localparam int unsigned ID_W       = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [VADDR_BITS-1:0] vaddr_base,
    input  logic [NPAGE_BITS-1:0] n_pages,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           cycles,
    output logic                  err,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [VADDR_BITS-1:0] req_vaddr,
    output logic [31:0]           req_len,
    output logic [ID_W-1:0]       req_core,
    input  logic [N_CORES-1:0]    cmp_valid
);

    localparam int unsigned PAGE_SHIFT = $clog2(PAGE_SIZE);
    localparam int unsigned CRED_W     = $clog2(CREDITS + 1);

    sched_state_t          state;
    logic [VADDR_BITS-1:0] base;
    logic [NPAGE_BITS-1:0] npages;
    logic [NPAGE_BITS-1:0] issued;
    logic [NPAGE_BITS-1:0] completed;
    logic [31:0]           cyc_cnt;
    logic [ID_W-1:0]       rr_ptr;
    logic [CRED_W-1:0]     credit     [N_CORES];

    logic                  hs;
    logic [NPAGE_BITS-1:0] issued_nxt;
    logic [NPAGE_BITS-1:0] n_ok;
    logic [ID_W-1:0]       ptr_nxt;
    logic [N_CORES-1:0]    cmp_ok;
    logic [N_CORES-1:0]    cmp_bad;
    logic [N_CORES-1:0]    elig_nxt;
    logic [CRED_W-1:0]     credit_nxt [N_CORES];
    logic [VADDR_BITS-1:0] page_off;
    logic [ID_W-1:0]       grant;
    logic                  any_grant;

    assign req_len = 32'(PAGE_SIZE);

    // Next-cycle credits, pointer and issue index; the next request is chosen
    // from post-update credits so a handshake can be followed back-to-back.
    always_comb begin
        hs         = req_valid && req_ready;
        issued_nxt = issued + NPAGE_BITS'(hs);
        ptr_nxt    = rr_ptr;
        if (hs) begin
            ptr_nxt = (32'(req_core) == N_CORES - 1) ? '0 : req_core + ID_W'(1);
        end
        n_ok     = '0;
        cmp_ok   = '0;
        cmp_bad  = '0;
        elig_nxt = '0;
        for (int unsigned c = 0; c < N_CORES; c++) begin
            credit_nxt[c] = credit[c];
            cmp_ok[c]     = cmp_valid[c] && (state != IDLE) && (credit[c] != CRED_W'(CREDITS));
            cmp_bad[c]    = cmp_valid[c] && !cmp_ok[c];
            if (hs && (req_core == ID_W'(c))) begin
                credit_nxt[c] = credit_nxt[c] - CRED_W'(1);
            end
            if (cmp_ok[c]) begin
                credit_nxt[c] = credit_nxt[c] + CRED_W'(1);
            end
            elig_nxt[c] = (credit_nxt[c] != '0);
            n_ok        = n_ok + NPAGE_BITS'(cmp_ok[c]);
        end
        page_off = VADDR_BITS'(issued_nxt) << PAGE_SHIFT;
    end

    rr_credit_arbiter #(
        .N_CORES (N_CORES)
    ) u_arb (
        .eligible  (elig_nxt),
        .ptr       (ptr_nxt),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // Job FSM, counters, credits and registered request outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cycles    <= '0;
            req_valid <= 1'b0;
            req_vaddr <= '0;
            req_core  <= '0;
            rr_ptr    <= '0;
            base      <= '0;
            npages    <= '0;
            issued    <= '0;
            completed <= '0;
            cyc_cnt   <= '0;
            for (int unsigned c = 0; c < N_CORES; c++) begin
                credit[c] <= CRED_W'(CREDITS);
            end
        end else begin
            done      <= 1'b0;
            rr_ptr    <= ptr_nxt;
            credit    <= credit_nxt;
            completed <= completed + n_ok;
            if (hs) begin
                issued <= issued_nxt;
            end
            if (|cmp_bad) begin
                err <= 1'b1;
            end
            if ((state != IDLE) && (cyc_cnt != '1)) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        base      <= vaddr_base;
                        npages    <= n_pages;
                        issued    <= '0;
                        completed <= '0;
                        cyc_cnt   <= '0;
                        err       <= |cmp_bad;
                        if (n_pages == '0) begin
                            state <= FIN;
                        end else begin
                            state     <= ISSUE;
                            req_valid <= any_grant;
                            req_vaddr <= vaddr_base;
                            req_core  <= grant;
                        end
                    end
                end
                ISSUE: begin
                    if (!req_valid || hs) begin
                        if (issued_nxt == npages) begin
                            req_valid <= 1'b0;
                            state     <= DRAIN;
                        end else if (any_grant) begin
                            req_valid <= 1'b1;
                            req_vaddr <= base + page_off;
                            req_core  <= grant;
                        end else begin
                            req_valid <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (completed == npages) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    done   <= 1'b1;
                    cycles <= (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 32'd1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
